// File: rtl/aes_key_schedule_iter.sv
// ----------------------------------------------------------------------------
// aes_sbox
//   Forward AES S-box for one byte, as a constant lookup table.
//   Ports:
//     byte_val  in   8   byte to substitute
//     sub_val   out  8   S-box image of byte_val
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    // Entry 0x00 sits in the top byte, entry 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Bit offset of entry x is 8*(255-x); 255-x is simply ~x for a byte.
    logic [10:0] table_ofs;

    assign table_ofs = {~byte_val, 3'b000};
    assign sub_val   = SBOX_TABLE[table_ofs +: 8];

endmodule

// ----------------------------------------------------------------------------
// aes_key_schedule_iter
//   Iterative AES-128/192/256 key expansion. One 32-bit schedule word is
//   produced per clock through a single 4-byte S-box lane; all words are kept
//   in a local store and served as 128-bit round keys by round index.
//   Parameters:
//     MAX_WORDS  depth of the word store (60 covers AES-256)
//     RD_LAT     round-key read latency, 1 or 2 cycles
//   Ports:
//     clk          in   1    clock, rising edge
//     rst          in   1    synchronous active-high reset
//     start        in   1    begin expansion (honoured only when idle)
//     key_len      in   2    00=128, 01=192, 10=256, 11=128
//     key_in       in   256  cipher key, MSB-aligned (w[0] = key_in[255:224])
//     busy         out  1    expansion in progress
//     done         out  1    single-cycle completion pulse
//     rk_valid     out  1    stored schedule is complete
//     nr           out  4    round count of the latched mode
//     rk_rd_en     in   1    round-key read request
//     rk_rd_idx    in   4    round index 0..nr
//     rk_rd_data   out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//     rk_rd_valid  out  1    rk_rd_data valid, RD_LAT cycles after request
// ----------------------------------------------------------------------------
module aes_key_schedule_iter #(
    parameter int MAX_WORDS = 60,
    parameter int RD_LAT    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     key_len,
    input  logic [255:0]   key_in,
    output logic           busy,
    output logic           done,
    output logic           rk_valid,
    output logic [3:0]     nr,
    input  logic           rk_rd_en,
    input  logic [3:0]     rk_rd_idx,
    output logic [127:0]   rk_rd_data,
    output logic           rk_rd_valid
);

    localparam int AW = $clog2(MAX_WORDS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [31:0]   w_mem [MAX_WORDS];

    logic [3:0]    nk_q;
    logic [3:0]    nr_q;
    logic [AW-1:0] i_q;
    logic [AW-1:0] last_q;
    logic [2:0]    kpos_q;      // i mod Nk, tracked incrementally
    logic [7:0]    rcon_q;
    logic          done_q;
    logic          rk_valid_q;

    logic [3:0]    nk_new;
    logic [3:0]    nr_new;
    logic          start_go;
    logic          step;
    logic          last_word;

    logic [31:0]   prev_word;
    logic [31:0]   back_word;
    logic          rot_sel;
    logic          sub_only;
    logic [31:0]   sbox_in;
    logic [31:0]   sbox_out;
    logic [31:0]   temp_word;
    logic [31:0]   new_word;

    logic          rd_ok;
    logic [AW-1:0] rd_base;
    logic [127:0]  rd_word;
    logic [127:0]  rd_data_p1;
    logic          vld_p1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Mode decode; the reserved encoding falls back to AES-128.
    always_comb begin
        nk_new = 4'd4;
        nr_new = 4'd10;
        unique case (key_len)
            2'b01: begin
                nk_new = 4'd6;
                nr_new = 4'd12;
            end
            2'b10: begin
                nk_new = 4'd8;
                nr_new = 4'd14;
            end
            default: begin
                nk_new = 4'd4;
                nr_new = 4'd10;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        start_go  = 1'b0;
        step      = 1'b0;
        last_word = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    start_go = 1'b1;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                step      = 1'b1;
                last_word = (i_q == last_q);
                if (last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word generator. The S-box lane is shared: it sees RotWord(temp) on
    // i mod Nk == 0 and plain temp on the AES-256 i mod 8 == 4 step; the two
    // cases never coincide.
    always_comb begin
        prev_word = w_mem[i_q - AW'(1)];
        back_word = w_mem[i_q - AW'(nk_q)];
        rot_sel   = (kpos_q == 3'd0);
        sub_only  = (nk_q == 4'd8) && (kpos_q == 3'd4);
        sbox_in   = rot_sel ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        if (rot_sel) begin
            temp_word = sbox_out ^ {rcon_q, 24'h000000};
        end else if (sub_only) begin
            temp_word = sbox_out;
        end else begin
            temp_word = prev_word;
        end
        new_word = back_word ^ temp_word;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_val (sbox_in[8*b +: 8]),
            .sub_val  (sbox_out[8*b +: 8])
        );
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            nr_q       <= 4'd0;
            nk_q       <= 4'd4;
            i_q        <= '0;
            last_q     <= '0;
            kpos_q     <= 3'd0;
            rcon_q     <= 8'h01;
        end else begin
            state_q <= state_d;
            done_q  <= step && last_word;
            if (start_go) begin
                nk_q       <= nk_new;
                nr_q       <= nr_new;
                last_q     <= AW'({nr_new, 2'b11});   // 4*Nr+3
                i_q        <= AW'(nk_new);
                kpos_q     <= 3'd0;
                rcon_q     <= 8'h01;
                rk_valid_q <= 1'b0;
            end else if (step) begin
                i_q    <= i_q + AW'(1);
                kpos_q <= ({1'b0, kpos_q} == nk_q - 4'd1) ? 3'd0 : kpos_q + 3'd1;
                if (kpos_q == 3'd0) begin
                    rcon_q <= xtime(rcon_q);
                end
                if (last_word) begin
                    rk_valid_q <= 1'b1;
                end
            end
        end
    end

    // Word store: the key words land on the start edge, one derived word per
    // EXPAND edge afterwards. Not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (start_go) begin
                for (int j = 0; j < 8; j++) begin
                    if (j < int'(nk_new)) begin
                        w_mem[AW'(j)] <= key_in[255-32*j -: 32];
                    end
                end
            end else if (step) begin
                w_mem[i_q] <= new_word;
            end
        end
    end

    // Read port: out-of-range index or an incomplete schedule returns zero
    // but still produces a valid beat.
    always_comb begin
        rd_ok   = rk_valid_q && (rk_rd_idx <= nr_q);
        rd_base = AW'({rk_rd_idx, 2'b00});
        rd_word = {w_mem[rd_base],
                   w_mem[rd_base + AW'(1)],
                   w_mem[rd_base + AW'(2)],
                   w_mem[rd_base + AW'(3)]};
    end

    // ---- read stage p1 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rk_rd_en;
            if (rk_rd_en) begin
                rd_data_p1 <= rd_ok ? rd_word : '0;
            end
        end
    end

    if (RD_LAT == 2) begin : g_rd_p2
        logic [127:0] rd_data_p2;
        logic         vld_p2;

        // ---- read stage p2 ----
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_p2 <= '0;
                vld_p2     <= 1'b0;
            end else begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    rd_data_p2 <= rd_data_p1;
                end
            end
        end

        assign rk_rd_data  = rd_data_p2;
        assign rk_rd_valid = vld_p2;
    end else begin : g_rd_p1
        assign rk_rd_data  = rd_data_p1;
        assign rk_rd_valid = vld_p1;
    end

    assign busy     = (state_q == EXPAND);
    assign done     = done_q;
    assign rk_valid = rk_valid_q;
    assign nr       = nr_q;

endmodule
